// File: rtl/id_ex_ctrl_pipe.sv
// rtl/id_ex_ctrl_pipe.sv - ID/EX main controller with load-use, flush, hold and illegal-opcode handling
module id_ex_ctrl_pipe #(
    parameter int REG_ADDR_W      = 5,
    parameter int ALUOP_W         = 3,
    parameter int EN_AUIPC        = 1,
    parameter int HALT_ON_ILLEGAL = 1,
    parameter int CNT_W           = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  flush,
    input  logic                  hold,
    output logic                  ex_valid,
    output logic                  ex_alusrc,
    output logic                  ex_memtoreg,
    output logic                  ex_regwrite,
    output logic                  ex_memread,
    output logic                  ex_memwrite,
    output logic                  ex_branch,
    output logic                  ex_auipc,
    output logic [ALUOP_W-1:0]    ex_aluop,
    output logic [1:0]            ex_jaltype,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  illegal_op,
    output logic                  halted,
    output logic [CNT_W-1:0]      lu_bubbles
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef struct packed {
        logic                  valid;
        logic                  alusrc;
        logic                  memtoreg;
        logic                  regwrite;
        logic                  memread;
        logic                  memwrite;
        logic                  branch;
        logic                  auipc;
        logic [ALUOP_W-1:0]    aluop;
        logic [1:0]            jaltype;
        logic [REG_ADDR_W-1:0] rd;
    } ctl_t;

    ctl_t             r_ex;
    ctl_t             w_dec;
    logic [0:0]       r_state;
    logic             r_illegal_op;
    logic [CNT_W-1:0] r_lu_cnt;

    logic w_is_r, w_is_lw, w_is_sw, w_is_br, w_is_jal, w_is_jalr, w_is_i, w_is_lui, w_is_auipc;
    logic w_legal, w_illegal, w_uses_rs1, w_uses_rs2, w_lu, w_halted;

    // Opcode decode; an invalid ID slot decodes to an all-zero bubble
    always_comb begin
        w_is_r      = (id_opcode == OP_R);
        w_is_lw     = (id_opcode == OP_LW);
        w_is_sw     = (id_opcode == OP_SW);
        w_is_br     = (id_opcode == OP_BR);
        w_is_jal    = (id_opcode == OP_JAL);
        w_is_jalr   = (id_opcode == OP_JALR);
        w_is_i      = (id_opcode == OP_I);
        w_is_lui    = (id_opcode == OP_LUI);
        w_is_auipc  = (EN_AUIPC != 0) && (id_opcode == OP_AUIPC);
        w_legal     = w_is_r | w_is_lw | w_is_sw | w_is_br | w_is_jal | w_is_jalr
                    | w_is_i | w_is_lui | w_is_auipc;
        w_illegal   = id_valid & ~w_legal;
        w_uses_rs1  = w_is_r | w_is_i | w_is_lw | w_is_sw | w_is_br | w_is_jalr;
        w_uses_rs2  = w_is_r | w_is_sw | w_is_br;

        w_dec          = '0;
        w_dec.valid    = id_valid;
        w_dec.alusrc   = id_valid & (w_is_lw | w_is_sw | w_is_jalr | w_is_i | w_is_lui | w_is_auipc);
        w_dec.regwrite = id_valid & (w_is_r | w_is_lw | w_is_jal | w_is_jalr | w_is_i | w_is_lui | w_is_auipc);
        w_dec.memtoreg = id_valid & w_is_lw;
        w_dec.memread  = id_valid & w_is_lw;
        w_dec.memwrite = id_valid & w_is_sw;
        w_dec.branch   = id_valid & w_is_br;
        w_dec.auipc    = id_valid & w_is_auipc;
        w_dec.jaltype  = {id_valid & w_is_jal, id_valid & w_is_jalr};
        if (id_valid) begin
            w_dec.rd = id_rd;
            if (w_is_br)
                w_dec.aluop[2:0] = 3'b001;
            else if (w_is_r | w_is_jal | w_is_jalr)
                w_dec.aluop[2:0] = 3'b010;
            else if (w_is_i)
                w_dec.aluop[2:0] = 3'b011;
            else if (w_is_lui | w_is_auipc)
                w_dec.aluop[2:0] = 3'b100;
            else
                w_dec.aluop[2:0] = 3'b000;
        end
    end

    // Load-use hazard: a load in EX whose destination a source of the ID instruction needs
    always_comb begin
        w_lu = id_valid & r_ex.valid & r_ex.memread & (r_ex.rd != '0)
             & ((w_uses_rs1 & (r_ex.rd == id_rs1)) | (w_uses_rs2 & (r_ex.rd == id_rs2)));
        w_halted = (r_state == S_HALT);
    end

    // Front-end enables follow the same priority as the ID/EX update
    always_comb begin
        pc_write = 1'b1;
        if (hold)
            pc_write = 1'b0;
        else if (w_halted)
            pc_write = 1'b0;
        else if (flush)
            pc_write = 1'b1;
        else if (w_lu)
            pc_write = 1'b0;
        if_id_write = pc_write;
    end

    // ID/EX control register, halt state, illegal pulse and load-use counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex         <= '0;
            r_state      <= S_RUN;
            r_illegal_op <= 1'b0;
            r_lu_cnt     <= '0;
        end else begin
            r_illegal_op <= 1'b0;
            if (!hold) begin
                if (w_halted || flush || w_lu || w_illegal) begin
                    r_ex <= '0;
                    if (!w_halted && !flush && w_lu && (r_lu_cnt != '1))
                        r_lu_cnt <= r_lu_cnt + CNT_ONE;
                    if (!w_halted && !flush && !w_lu && w_illegal) begin
                        r_illegal_op <= 1'b1;
                        if (HALT_ON_ILLEGAL != 0)
                            r_state <= S_HALT;
                    end
                end else begin
                    r_ex <= w_dec;
                end
            end
        end
    end

    assign ex_valid    = r_ex.valid;
    assign ex_alusrc   = r_ex.alusrc;
    assign ex_memtoreg = r_ex.memtoreg;
    assign ex_regwrite = r_ex.regwrite;
    assign ex_memread  = r_ex.memread;
    assign ex_memwrite = r_ex.memwrite;
    assign ex_branch   = r_ex.branch;
    assign ex_auipc    = r_ex.auipc;
    assign ex_aluop    = r_ex.aluop;
    assign ex_jaltype  = r_ex.jaltype;
    assign ex_rd       = r_ex.rd;
    assign illegal_op  = r_illegal_op;
    assign halted      = w_halted;
    assign lu_bubbles  = r_lu_cnt;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// tb/tb_id_ex_ctrl_pipe.sv - directed table-driven bench for id_ex_ctrl_pipe
module tb_id_ex_ctrl_pipe;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [6:0] id_opcode = '0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       flush = 1'b0, hold = 1'b0;

    logic       a_ex_valid, a_ex_alusrc, a_ex_memtoreg, a_ex_regwrite, a_ex_memread, a_ex_memwrite;
    logic       a_ex_branch, a_ex_auipc, a_pc_write, a_if_id_write, a_illegal_op, a_halted;
    logic [2:0] a_ex_aluop;
    logic [1:0] a_ex_jaltype;
    logic [4:0] a_ex_rd;
    logic [15:0] a_lu_bubbles;

    logic       b_ex_valid, b_ex_alusrc, b_ex_memtoreg, b_ex_regwrite, b_ex_memread, b_ex_memwrite;
    logic       b_ex_branch, b_ex_auipc, b_pc_write, b_if_id_write, b_illegal_op, b_halted;
    logic [2:0] b_ex_aluop;
    logic [1:0] b_ex_jaltype;
    logic [4:0] b_ex_rd;
    logic [1:0] b_lu_bubbles;

    always #5 clk = ~clk;

    id_ex_ctrl_pipe dut_a (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush), .hold(hold),
        .ex_valid(a_ex_valid), .ex_alusrc(a_ex_alusrc), .ex_memtoreg(a_ex_memtoreg),
        .ex_regwrite(a_ex_regwrite), .ex_memread(a_ex_memread), .ex_memwrite(a_ex_memwrite),
        .ex_branch(a_ex_branch), .ex_auipc(a_ex_auipc), .ex_aluop(a_ex_aluop),
        .ex_jaltype(a_ex_jaltype), .ex_rd(a_ex_rd), .pc_write(a_pc_write),
        .if_id_write(a_if_id_write), .illegal_op(a_illegal_op), .halted(a_halted),
        .lu_bubbles(a_lu_bubbles)
    );

    id_ex_ctrl_pipe #(.EN_AUIPC(0), .HALT_ON_ILLEGAL(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush), .hold(hold),
        .ex_valid(b_ex_valid), .ex_alusrc(b_ex_alusrc), .ex_memtoreg(b_ex_memtoreg),
        .ex_regwrite(b_ex_regwrite), .ex_memread(b_ex_memread), .ex_memwrite(b_ex_memwrite),
        .ex_branch(b_ex_branch), .ex_auipc(b_ex_auipc), .ex_aluop(b_ex_aluop),
        .ex_jaltype(b_ex_jaltype), .ex_rd(b_ex_rd), .pc_write(b_pc_write),
        .if_id_write(b_if_id_write), .illegal_op(b_illegal_op), .halted(b_halted),
        .lu_bubbles(b_lu_bubbles)
    );

    typedef struct {
        logic [6:0]  op;
        logic        v, fl, ho;
        logic [4:0]  rs1, rs2, rd;
        logic        pcw;
        logic        ev;
        logic [6:0]  ctl;   // {alusrc, memtoreg, regwrite, memread, memwrite, branch, auipc}
        logic [2:0]  aluop;
        logic [1:0]  jal;
        logic [4:0]  erd;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];
    int total = 0;
    int bad = 0;

    function automatic vec_t mk(input logic [6:0] op, input logic v, input logic fl, input logic ho,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic pcw, input logic ev, input logic [6:0] ctl,
                                input logic [2:0] aluop, input logic [1:0] jal,
                                input logic [4:0] erd, input logic [15:0] cnt);
        vec_t t;
        t.op = op; t.v = v; t.fl = fl; t.ho = ho; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
        t.pcw = pcw; t.ev = ev; t.ctl = ctl; t.aluop = aluop; t.jal = jal; t.erd = erd; t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic v, input logic fl, input logic ho,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        id_opcode = op; id_valid = v; flush = fl; hold = ho;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(OP_R, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = mk(OP_R,    1,0,0, 2,3,1, 1,1,7'b0010000,3'b010,2'b00,1,0);
        vecs[1]  = mk(OP_LW,   1,0,0, 1,0,4, 1,1,7'b1111000,3'b000,2'b00,4,0);
        vecs[2]  = mk(OP_SW,   1,0,0, 2,3,9, 1,1,7'b1000100,3'b000,2'b00,9,0);
        vecs[3]  = mk(OP_BR,   1,0,0, 1,2,0, 1,1,7'b0000010,3'b001,2'b00,0,0);
        vecs[4]  = mk(OP_JAL,  1,0,0, 0,0,1, 1,1,7'b0010000,3'b010,2'b10,1,0);
        vecs[5]  = mk(OP_JALR, 1,0,0, 3,0,2, 1,1,7'b1010000,3'b010,2'b01,2,0);
        vecs[6]  = mk(OP_I,    1,0,0, 4,0,3, 1,1,7'b1010000,3'b011,2'b00,3,0);
        vecs[7]  = mk(OP_LUI,  1,0,0, 0,0,5, 1,1,7'b1010000,3'b100,2'b00,5,0);
        vecs[8]  = mk(OP_AUIPC,1,0,0, 0,0,6, 1,1,7'b1010001,3'b100,2'b00,6,0);
        vecs[9]  = mk(OP_R,    0,0,0, 2,3,1, 1,0,7'b0000000,3'b000,2'b00,0,0);
        vecs[10] = mk(OP_I,    1,0,0, 1,0,7, 1,1,7'b1010000,3'b011,2'b00,7,0);
        vecs[11] = mk(OP_LW,   1,0,1, 1,0,8, 0,1,7'b1010000,3'b011,2'b00,7,0);
        vecs[12] = mk(OP_LW,   1,1,0, 1,0,8, 1,0,7'b0000000,3'b000,2'b00,0,0);
        vecs[13] = mk(OP_LW,   1,0,0, 1,0,5, 1,1,7'b1111000,3'b000,2'b00,5,0);
        vecs[14] = mk(OP_R,    1,0,0, 5,7,6, 0,0,7'b0000000,3'b000,2'b00,0,1);
        vecs[15] = mk(OP_R,    1,0,0, 5,7,6, 1,1,7'b0010000,3'b010,2'b00,6,1);
        vecs[16] = mk(OP_LW,   1,0,0, 1,0,0, 1,1,7'b1111000,3'b000,2'b00,0,1);
        vecs[17] = mk(OP_R,    1,0,0, 0,0,6, 1,1,7'b0010000,3'b010,2'b00,6,1);
        vecs[18] = mk(OP_LW,   1,0,0, 1,0,5, 1,1,7'b1111000,3'b000,2'b00,5,1);
        vecs[19] = mk(OP_R,    1,1,0, 1,5,6, 1,0,7'b0000000,3'b000,2'b00,0,1);
        vecs[20] = mk(OP_LW,   1,0,0, 1,0,5, 1,1,7'b1111000,3'b000,2'b00,5,1);
        vecs[21] = mk(OP_R,    1,1,1, 5,0,6, 0,1,7'b1111000,3'b000,2'b00,5,1);
        vecs[22] = mk(OP_R,    1,0,0, 5,0,6, 0,0,7'b0000000,3'b000,2'b00,0,2);
        vecs[23] = mk(OP_R,    1,0,0, 5,0,6, 1,1,7'b0010000,3'b010,2'b00,6,2);
        vecs[24] = mk(OP_LW,   1,0,0, 1,0,9, 1,1,7'b1111000,3'b000,2'b00,9,2);
        vecs[25] = mk(OP_SW,   1,0,0, 0,9,3, 0,0,7'b0000000,3'b000,2'b00,0,3);
        vecs[26] = mk(OP_SW,   1,0,0, 0,9,3, 1,1,7'b1000100,3'b000,2'b00,3,3);
        vecs[27] = mk(OP_LW,   1,0,0, 2,0,1, 1,1,7'b1111000,3'b000,2'b00,1,3);
        vecs[28] = mk(OP_JAL,  1,0,0, 1,0,2, 1,1,7'b0010000,3'b010,2'b10,2,3);

        // reset state
        reset_n = 1'b0;
        tick();
        tick();
        chk("reset a_ex_valid", a_ex_valid, 0);
        chk("reset a_ctl", {a_ex_alusrc, a_ex_memtoreg, a_ex_regwrite, a_ex_memread,
                            a_ex_memwrite, a_ex_branch, a_ex_auipc}, 0);
        chk("reset a_aluop", a_ex_aluop, 0);
        chk("reset a_rd", a_ex_rd, 0);
        chk("reset a_illegal", a_illegal_op, 0);
        chk("reset a_halted", a_halted, 0);
        chk("reset a_lu", a_lu_bubbles, 0);
        chk("reset b_ex_valid", b_ex_valid, 0);
        reset_n = 1'b1;

        // table-driven vectors on the default-parameter instance
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].op, vecs[i].v, vecs[i].fl, vecs[i].ho, vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
            #1;
            chk($sformatf("v%0d pc_write", i), a_pc_write, vecs[i].pcw);
            chk($sformatf("v%0d if_id_write", i), a_if_id_write, vecs[i].pcw);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ex_valid", i), a_ex_valid, vecs[i].ev);
            chk($sformatf("v%0d ctl", i), {a_ex_alusrc, a_ex_memtoreg, a_ex_regwrite, a_ex_memread,
                                           a_ex_memwrite, a_ex_branch, a_ex_auipc}, vecs[i].ctl);
            chk($sformatf("v%0d aluop", i), a_ex_aluop, vecs[i].aluop);
            chk($sformatf("v%0d jaltype", i), a_ex_jaltype, vecs[i].jal);
            chk($sformatf("v%0d ex_rd", i), a_ex_rd, vecs[i].erd);
            chk($sformatf("v%0d lu_bubbles", i), a_lu_bubbles, vecs[i].cnt);
            chk($sformatf("v%0d illegal_op", i), a_illegal_op, 0);
        end

        // illegal opcode: A halts, B bubbles and continues
        do_reset();
        drive(OP_BAD, 1, 0, 0, 0, 0, 1);
        tick();
        chk("ill a_pulse", a_illegal_op, 1);
        chk("ill a_halted", a_halted, 1);
        chk("ill a_ex_valid", a_ex_valid, 0);
        chk("ill b_pulse", b_illegal_op, 1);
        chk("ill b_halted", b_halted, 0);
        chk("ill b_ex_valid", b_ex_valid, 0);
        drive(OP_R, 1, 0, 0, 2, 3, 1);
        #1;
        chk("halt a_pc_write", a_pc_write, 0);
        chk("halt a_if_id_write", a_if_id_write, 0);
        chk("halt b_pc_write", b_pc_write, 1);
        tick();
        chk("halt a_pulse_once", a_illegal_op, 0);
        chk("halt a_ex_valid", a_ex_valid, 0);
        chk("cont b_ex_valid", b_ex_valid, 1);
        chk("cont b_ex_rd", b_ex_rd, 1);
        chk("cont b_pulse_once", b_illegal_op, 0);
        tick();
        chk("halt a_still", a_halted, 1);
        chk("halt a_pc_write2", a_pc_write, 0);
        reset_n = 1'b0;
        #1;
        chk("halt reset a_halted", a_halted, 0);
        chk("halt reset a_pc_write", a_pc_write, 1);
        tick();
        reset_n = 1'b1;

        // AUIPC disabled on B; flushed illegal never pulses
        drive(OP_AUIPC, 1, 0, 0, 0, 0, 4);
        tick();
        chk("auipc a_ex_auipc", a_ex_auipc, 1);
        chk("auipc a_pulse", a_illegal_op, 0);
        chk("auipc b_pulse", b_illegal_op, 1);
        chk("auipc b_ex_valid", b_ex_valid, 0);
        drive(OP_BAD, 1, 1, 0, 0, 0, 1);
        #1;
        chk("flush ill a_pc_write", a_pc_write, 1);
        tick();
        chk("flush ill a_pulse", a_illegal_op, 0);
        chk("flush ill a_halted", a_halted, 0);
        chk("flush ill b_pulse", b_illegal_op, 0);
        chk("flush ill a_ex_valid", a_ex_valid, 0);

        // five load-use events: B saturates at 3
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(OP_LW, 1, 0, 0, 1, 0, 5);
            tick();
            drive(OP_R, 1, 0, 0, 5, 7, 6);
            tick();
        end
        chk("sat b_lu", b_lu_bubbles, 3);
        chk("sat a_lu", a_lu_bubbles, 5);

        // asynchronous reset in the middle of a stall
        drive(OP_LW, 1, 0, 0, 1, 0, 5);
        tick();
        drive(OP_R, 1, 0, 0, 5, 7, 6);
        #1;
        chk("stall a_pc_write", a_pc_write, 0);
        chk("stall a_ex_memread", a_ex_memread, 1);
        reset_n = 1'b0;
        #1;
        chk("async a_ex_valid", a_ex_valid, 0);
        chk("async a_ex_memread", a_ex_memread, 0);
        chk("async a_ex_rd", a_ex_rd, 0);
        chk("async a_lu", a_lu_bubbles, 0);
        chk("async b_lu", b_lu_bubbles, 0);
        chk("async a_pc_write", a_pc_write, 1);
        tick();
        reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
